sdp_erd_mcif_responder: RTL and testbench

Memory-side responder for the SDP element-wise read DMA channel. It accepts ERDMA read requests on the `sdp_e2mcif_rd_req_*` interface and reads the requested 8-byte atoms from a single-cycle-latency SRAM port. It returns them on the `mcif2sdp_e_rd_rsp_*` interface. Response issue is limited by a credit counter that models the requester's latency FIFO and is replenished by `sdp_e2mcif_rd_cdt_lat_fifo_pop`. The block is used as the MCIF stand-in for ERDMA in block-level integration and FPGA bring-up.

---
 rtl/sdp_erd_mcif_responder.sv | 151 +++++++++++++++
 tb/tb_sdp_erd_mcif_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_erd_mcif_responder.sv
// sdp_erd_mcif_responder
// Memory-side stand-in for the ERDMA read path. Accepts burst read requests,
// reads 8-byte atoms from a single-cycle SRAM, and returns them in order.
// Reads are gated by a credit count that mirrors the requester's latency
// FIFO. The response buffer is a 2-entry queue whose youngest slot may be
// the SRAM read still on its way (in-flight), so data returns two cycles
// after the request is accepted.
module sdp_erd_mcif_responder #(
    parameter int LAT_FIFO_DEPTH = 16,
    parameter int CW             = $clog2(LAT_FIFO_DEPTH + 1)
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          sdp_e2mcif_rd_req_valid,
    output logic          sdp_e2mcif_rd_req_ready,
    input  logic [46:0]   sdp_e2mcif_rd_req_pd,
    output logic          mcif2sdp_e_rd_rsp_valid,
    input  logic          mcif2sdp_e_rd_rsp_ready,
    output logic [64:0]   mcif2sdp_e_rd_rsp_pd,
    input  logic          sdp_e2mcif_rd_cdt_lat_fifo_pop,
    output logic          mem_rd_en,
    output logic [28:0]   mem_rd_addr,
    input  logic [63:0]   mem_rd_data,
    output logic [CW-1:0] credit_cnt,
    output logic          cdt_overflow,
    output logic          busy
);

    typedef enum logic {IDLE, BURST} state_e;

    localparam logic [CW-1:0] CDT_MAX = CW'(LAT_FIFO_DEPTH);

    state_e       state_q, state_d;
    logic [28:0]  base_q, base_d;
    logic [15:0]  beats_left_q, beats_left_d;
    logic [15:0]  beat_idx_q, beat_idx_d;
    logic         inflight_q;
    logic [1:0][63:0] buf_q;
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   buf_cnt_q, buf_cnt_d;
    logic [CW-1:0] credit_q, credit_d;
    logic         ovf_q;

    logic         req_fire;
    logic         issue;
    logic [1:0]   occ;
    logic [63:0]  head_data;
    logic         rsp_fire;
    logic         rsp_direct;
    logic         buf_wr;
    logic         buf_rd;
    logic         pop_take;
    logic         ovf_set;

    // Address low bits are discarded; keep them visibly consumed.
    logic         unused_addr_lsb;
    assign unused_addr_lsb = ^sdp_e2mcif_rd_req_pd[2:0];

    // Occupancy counts stored entries plus the read arriving this cycle.
    assign occ = buf_cnt_q + {1'b0, inflight_q};

    // FSM next-state, request handshake and SRAM read issue.
    always_comb begin
        state_d                 = state_q;
        base_d                  = base_q;
        beats_left_d            = beats_left_q;
        beat_idx_d              = beat_idx_q;
        sdp_e2mcif_rd_req_ready = 1'b0;
        issue                   = 1'b0;
        req_fire                = 1'b0;
        unique case (state_q)
            IDLE: begin
                sdp_e2mcif_rd_req_ready = 1'b1;
                req_fire = sdp_e2mcif_rd_req_valid;
                if (req_fire) begin
                    base_d       = sdp_e2mcif_rd_req_pd[31:3];
                    beats_left_d = {1'b0, sdp_e2mcif_rd_req_pd[46:32]} + 16'd1;
                    beat_idx_d   = 16'd0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                issue = (credit_q != '0) && (occ < 2'd2);
                if (issue) begin
                    beats_left_d = beats_left_q - 16'd1;
                    beat_idx_d   = beat_idx_q + 16'd1;
                    if (beats_left_q == 16'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? (base_q + {13'd0, beat_idx_q}) : 29'd0;

    // Response head is the oldest stored entry, or the arriving SRAM word
    // when nothing is stored yet.
    assign head_data               = (buf_cnt_q != 2'd0) ? buf_q[rd_ptr_q] : mem_rd_data;
    assign mcif2sdp_e_rd_rsp_valid = (occ != 2'd0);
    assign mcif2sdp_e_rd_rsp_pd    = mcif2sdp_e_rd_rsp_valid ? {1'b1, head_data} : 65'd0;

    assign rsp_fire   = mcif2sdp_e_rd_rsp_valid && mcif2sdp_e_rd_rsp_ready;
    assign rsp_direct = rsp_fire && (buf_cnt_q == 2'd0);
    assign buf_wr     = inflight_q && !rsp_direct;
    assign buf_rd     = rsp_fire && (buf_cnt_q != 2'd0);
    assign buf_cnt_d  = buf_cnt_q + {1'b0, buf_wr} - {1'b0, buf_rd};

    // A returned credit is only lost when the counter is already full and
    // nothing is consumed the same cycle.
    assign pop_take = sdp_e2mcif_rd_cdt_lat_fifo_pop && ((credit_q != CDT_MAX) || issue);
    assign ovf_set  = sdp_e2mcif_rd_cdt_lat_fifo_pop && (credit_q == CDT_MAX) && !issue;
    assign credit_d = credit_q - CW'(issue) + CW'(pop_take);

    assign credit_cnt   = credit_q;
    assign cdt_overflow = ovf_q;
    assign busy         = (state_q != IDLE) || (occ != 2'd0);

    // Control state, counters and buffer pointers.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            beats_left_q <= '0;
            beat_idx_q   <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_cnt_q    <= '0;
            credit_q     <= CDT_MAX;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            beats_left_q <= beats_left_d;
            beat_idx_q   <= beat_idx_d;
            inflight_q   <= issue;
            buf_cnt_q    <= buf_cnt_d;
            credit_q     <= credit_d;
            if (buf_wr) wr_ptr_q <= ~wr_ptr_q;
            if (buf_rd) rd_ptr_q <= ~rd_ptr_q;
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    // Buffer storage; contents are don't-care until counted valid.
    always_ff @(posedge nvdla_core_clk) begin
        if (buf_wr) buf_q[wr_ptr_q] <= mem_rd_data;
    end

endmodule

// File: tb/tb_sdp_erd_mcif_responder.sv
// Bench for sdp_erd_mcif_responder: randomized bursts checked against an
// address/data/credit reference model built from the request stream.
module tb_sdp_erd_mcif_responder;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [46:0]   req_pd = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [64:0]   rsp_pd;
    logic          cdt_pop = 1'b0;
    logic          mem_rd_en;
    logic [28:0]   mem_rd_addr;
    logic [63:0]   mem_rd_data = '0;
    logic [CW-1:0] credit_cnt;
    logic          cdt_overflow;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [28:0] exp_addr[$];
    logic [28:0] obs_addr[$];
    int          obs_cyc[$];
    logic [64:0] obs_rsp[$];
    int          cred_model;
    bit          ovf_model;

    always #5 clk = ~clk;

    sdp_erd_mcif_responder #(.LAT_FIFO_DEPTH(DEPTH)) dut (
        .nvdla_core_clk                 (clk),
        .nvdla_core_rst                 (rst),
        .sdp_e2mcif_rd_req_valid        (req_valid),
        .sdp_e2mcif_rd_req_ready        (req_ready),
        .sdp_e2mcif_rd_req_pd           (req_pd),
        .mcif2sdp_e_rd_rsp_valid        (rsp_valid),
        .mcif2sdp_e_rd_rsp_ready        (rsp_ready),
        .mcif2sdp_e_rd_rsp_pd           (rsp_pd),
        .sdp_e2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
        .mem_rd_en                      (mem_rd_en),
        .mem_rd_addr                    (mem_rd_addr),
        .mem_rd_data                    (mem_rd_data),
        .credit_cnt                     (credit_cnt),
        .cdt_overflow                   (cdt_overflow),
        .busy                           (busy)
    );

    function automatic logic [63:0] fdat(input logic [28:0] a);
        return {3'b110, a, 3'b011, ~a};
    endfunction

    // SRAM: one-cycle read latency; garbage on cycles without a read.
    always @(posedge clk)
        mem_rd_data <= mem_rd_en ? fdat(mem_rd_addr) : {$urandom, $urandom};

    // Observe issued reads and accepted responses mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_rd_en) begin
                obs_addr.push_back(mem_rd_addr);
                obs_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) obs_rsp.push_back(rsp_pd);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_addr.delete();
        obs_addr.delete();
        obs_cyc.delete();
        obs_rsp.delete();
        cred_model = DEPTH;
        ovf_model  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; cdt_pop = 1'b0; rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    // Present one request; returns in the cycle after acceptance.
    task automatic send_req(input logic [31:0] a, input logic [14:0] sz);
        int k = 0;
        while (req_ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL req_accept_timeout: got req_ready=%b expected 1", req_ready);
        end
        req_pd    = {sz, a};
        req_valid = 1'b1;
        for (int i = 0; i <= int'(sz); i++) exp_addr.push_back(a[31:3] + 29'(i));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_pd !== 65'd0) begin n_fail++; $display("FAIL rst_rsp_pd: got %h expected 0", rsp_pd); end
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd_en: got %b expected 0", mem_rd_en); end
        n_cmp++; if (mem_rd_addr !== 29'd0) begin n_fail++; $display("FAIL rst_mem_rd_addr: got %h expected 0", mem_rd_addr); end
        n_cmp++; if (credit_cnt !== CW'(DEPTH)) begin n_fail++; $display("FAIL rst_credit: got %0d expected %0d", credit_cnt, DEPTH); end
        n_cmp++; if (cdt_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", cdt_overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        send_req(32'h100, 15'd0);
        n_cmp++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 29'h20) begin
            n_fail++; $display("FAIL single_issue: got en=%b addr=%h expected en=1 addr=20", mem_rd_en, mem_rd_addr);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_pd !== {1'b1, fdat(29'h20)}) begin
            n_fail++; $display("FAIL single_rsp: got v=%b pd=%h expected v=1 pd=%h", rsp_valid, rsp_pd, {1'b1, fdat(29'h20)});
        end
        n_cmp++;
        if (credit_cnt !== CW'(cred_model - 1)) begin
            n_fail++; $display("FAIL single_credit: got %0d expected %0d", credit_cnt, cred_model - 1);
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
    endtask

    task automatic test_burst4();
        int pops = 0;
        do_reset();
        rsp_ready = 1'b1;
        send_req(32'h40, 15'd3);
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                n_cmp++;
                if (mem_rd_en !== 1'b1 || mem_rd_addr !== 29'(8 + c)) begin
                    n_fail++; $display("FAIL burst4_issue%0d: got en=%b addr=%h expected en=1 addr=%h", c, mem_rd_en, mem_rd_addr, 29'(8 + c));
                end
            end
            cdt_pop = rsp_valid;
            if (rsp_valid) pops++;
            tick();
        end
        cdt_pop = 1'b0;
        n_cmp++;
        if (obs_rsp.size() != 4) begin n_fail++; $display("FAIL burst4_count: got %0d expected 4", obs_rsp.size()); end
        for (int i = 0; i < 4 && i < obs_rsp.size(); i++) begin
            n_cmp++;
            if (obs_rsp[i] !== {1'b1, fdat(exp_addr[i])}) begin
                n_fail++; $display("FAIL burst4_data%0d: got %h expected %h", i, obs_rsp[i], {1'b1, fdat(exp_addr[i])});
            end
        end
        n_cmp++;
        if (credit_cnt !== CW'(cred_model - 4 + pops)) begin
            n_fail++; $display("FAIL burst4_credit: got %0d expected %0d", credit_cnt, cred_model - 4 + pops);
        end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        rsp_ready = 1'b1;
        send_req($urandom, 15'(DEPTH + 3));
        repeat (30) tick();
        n_cmp++;
        if (obs_rsp.size() != DEPTH) begin n_fail++; $display("FAIL exhaust_count: got %0d expected %0d", obs_rsp.size(), DEPTH); end
        n_cmp++;
        if (credit_cnt !== '0 || busy !== 1'b1 || mem_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL exhaust_stall: got cdt=%0d busy=%b en=%b expected cdt=0 busy=1 en=0", credit_cnt, busy, mem_rd_en);
        end
        cdt_pop = 1'b1;
        tick();
        cdt_pop = 1'b0;
        n_cmp++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL exhaust_resume: got en=%b expected 1", mem_rd_en); end
        tick();
        n_cmp++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL exhaust_restall: got en=%b expected 0", mem_rd_en); end
        cdt_pop = 1'b1;
        tick();
        cdt_pop = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (obs_rsp.size() != DEPTH + 2) begin n_fail++; $display("FAIL exhaust_count2: got %0d expected %0d", obs_rsp.size(), DEPTH + 2); end
        for (int i = 0; i < DEPTH + 2 && i < obs_rsp.size(); i++) begin
            n_cmp++;
            if (obs_rsp[i] !== {1'b1, fdat(exp_addr[i])}) begin
                n_fail++; $display("FAIL exhaust_data%0d: got %h expected %h", i, obs_rsp[i], {1'b1, fdat(exp_addr[i])});
            end
        end
        n_cmp++;
        if (credit_cnt !== '0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL exhaust_final: got cdt=%0d busy=%b expected cdt=0 busy=1", credit_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [64:0] held;
        bit stable = 1'b1;
        int k = 0;
        do_reset();
        send_req($urandom, 15'd5);
        tick();
        held = rsp_pd;
        repeat (8) begin
            tick();
            if (rsp_pd !== held) stable = 1'b0;
        end
        n_cmp++;
        if (obs_addr.size() != 2) begin n_fail++; $display("FAIL bp_issued: got %0d expected 2", obs_addr.size()); end
        n_cmp++;
        if (!stable || rsp_valid !== 1'b1 || held !== {1'b1, fdat(exp_addr[0])}) begin
            n_fail++; $display("FAIL bp_hold: got v=%b pd=%h stable=%0d expected v=1 pd=%h stable=1", rsp_valid, held, stable, {1'b1, fdat(exp_addr[0])});
        end
        while ((obs_rsp.size() < 6 || busy) && k < 200) begin
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (obs_rsp.size() != 6 || obs_addr.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got rsp=%0d rd=%0d expected 6/6", obs_rsp.size(), obs_addr.size());
        end
        for (int i = 0; i < 6 && i < obs_rsp.size(); i++) begin
            n_cmp++;
            if (obs_rsp[i] !== {1'b1, fdat(exp_addr[i])}) begin
                n_fail++; $display("FAIL bp_data%0d: got %h expected %h", i, obs_rsp[i], {1'b1, fdat(exp_addr[i])});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rsp_ready = 1'b1;
        send_req($urandom, 15'd2);
        send_req($urandom, 15'd2);
        repeat (10) tick();
        n_cmp++;
        if (obs_cyc.size() != 6) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 6", obs_cyc.size());
        end else begin
            n_cmp++;
            if (obs_cyc[1] - obs_cyc[0] != 1) begin n_fail++; $display("FAIL b2b_rate: got gap %0d expected 1", obs_cyc[1] - obs_cyc[0]); end
            n_cmp++;
            if (obs_cyc[3] - obs_cyc[2] != 2) begin n_fail++; $display("FAIL b2b_bubble: got gap %0d expected 2", obs_cyc[3] - obs_cyc[2]); end
        end
        for (int i = 0; i < 6 && i < obs_rsp.size(); i++) begin
            n_cmp++;
            if (obs_rsp[i] !== {1'b1, fdat(exp_addr[i])}) begin
                n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", i, obs_rsp[i], {1'b1, fdat(exp_addr[i])});
            end
        end
    endtask

    task automatic test_wrap_ovf();
        do_reset();
        rsp_ready = 1'b1;
        send_req(32'hFFFF_FFF8, 15'd1);
        repeat (6) tick();
        n_cmp++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 29'h1FFF_FFFF || obs_addr[1] !== 29'h0) begin
            n_fail++; $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h expected n=2 1fffffff 0", obs_addr.size(), obs_addr[0], obs_addr[1]);
        end
        n_cmp++;
        if (obs_rsp.size() != 2 || obs_rsp[1] !== {1'b1, fdat(29'h0)}) begin
            n_fail++; $display("FAIL wrap_data: got n=%0d d1=%h expected n=2 d1=%h", obs_rsp.size(), obs_rsp[1], {1'b1, fdat(29'h0)});
        end
        cred_model -= 2;
        for (int p = 0; p < 3; p++) begin
            cdt_pop = 1'b1;
            tick();
            cdt_pop = 1'b0;
            if (cred_model < DEPTH) cred_model++;
            else ovf_model = 1'b1;
            n_cmp++;
            if (credit_cnt !== CW'(cred_model) || cdt_overflow !== ovf_model) begin
                n_fail++; $display("FAIL ovf_pop%0d: got cdt=%0d ovf=%b expected cdt=%0d ovf=%b", p, credit_cnt, cdt_overflow, cred_model, ovf_model);
            end
        end
        repeat (3) tick();
        n_cmp++; if (cdt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", cdt_overflow); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        do_reset();
        rsp_ready = 1'b1;
        send_req($urandom, 15'd9);
        tick();
        tick();
        n_cmp++; if (mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL midrst_beat3: got en=%b expected 1", mem_rd_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        n_cmp++;
        if (rsp_valid !== 1'b0 || mem_rd_en !== 1'b0 || credit_cnt !== CW'(DEPTH) || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: got v=%b en=%b cdt=%0d rdy=%b busy=%b expected 0 0 %0d 1 0", rsp_valid, mem_rd_en, credit_cnt, req_ready, busy, DEPTH);
        end
        a = $urandom;
        send_req(a, 15'd0);
        repeat (5) tick();
        n_cmp++;
        if (obs_rsp.size() != 1 || obs_rsp[0] !== {1'b1, fdat(a[31:3])} || credit_cnt !== CW'(DEPTH - 1)) begin
            n_fail++; $display("FAIL midrst_after: got n=%0d pd=%h cdt=%0d expected n=1 pd=%h cdt=%0d", obs_rsp.size(), obs_rsp[0], credit_cnt, {1'b1, fdat(a[31:3])}, DEPTH - 1);
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        int pops = 0;
        int k = 0;
        do_reset();
        fork
            begin
                for (int r = 0; r < 8; r++) send_req($urandom, 15'($urandom_range(0, 7)));
                done = 1'b1;
            end
            begin
                while (!(done && obs_rsp.size() == exp_addr.size() && !busy) && k < 3000) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    cdt_pop   = (pops < obs_rsp.size()) && ($urandom_range(0, 2) != 0);
                    if (cdt_pop) pops++;
                    tick();
                    k++;
                end
                rsp_ready = 1'b0;
                cdt_pop   = 1'b0;
            end
        join
        n_cmp++;
        if (obs_rsp.size() != exp_addr.size() || obs_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL rand_count: got rsp=%0d rd=%0d expected %0d", obs_rsp.size(), obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < obs_rsp.size() && i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[i] !== exp_addr[i] || obs_rsp[i] !== {1'b1, fdat(exp_addr[i])}) begin
                n_fail++; $display("FAIL rand_beat%0d: got addr=%h pd=%h expected addr=%h pd=%h", i, obs_addr[i], obs_rsp[i], exp_addr[i], {1'b1, fdat(exp_addr[i])});
            end
        end
        n_cmp++;
        if (credit_cnt !== CW'(DEPTH - exp_addr.size() + pops) || cdt_overflow !== 1'b0) begin
            n_fail++; $display("FAIL rand_credit: got cdt=%0d ovf=%b expected cdt=%0d ovf=0", credit_cnt, cdt_overflow, DEPTH - exp_addr.size() + pops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_credit_exhaust();
        test_backpressure();
        test_back_to_back();
        test_wrap_ovf();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
